// File: rtl/lsu_mem.sv
// lsu_mem: memory / write-back stage that sits directly after execute.
//
// Takes the load/store descriptor from execute. It issues one data-bus
// transaction for each load or store, and stalls execute until that transaction
// completes. It aligns and extends load data, and drives the single
// register-file write port. The write-back value is also the forwarding value
// returned to execute.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   lsu_op_typ_i              0 none, 1 load, 2 store
//   lsu_width_i               funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU
//   lsu_addr_i, lsu_wdata_i   byte address and store data from execute
//   rd_addr_i                 destination register of the op in execute
//   ex_result_i, ex_rd_addr_i, ex_we_rd_i   registered execute result
//   lsu_bp_o                  back-pressure to execute
//   dreq_*                    data-bus request channel (valid/ready)
//   dresp_*                   data-bus response channel (single-cycle pulse)
//   wb_value_o, wb_rd_addr_o, wb_we_o       register-file write port
//   lsu_trap_o, lsu_trap_cause_o, lsu_trap_addr_o   trap request
module lsu_mem #(
  parameter int unsigned TRAP_MISALIGN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  lsu_op_typ_i,
  input  logic [2:0]  lsu_width_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] ex_result_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_we_rd_i,
  output logic        lsu_bp_o,
  output logic        dreq_valid_o,
  input  logic        dreq_ready_i,
  output logic [31:0] dreq_addr_o,
  output logic        dreq_we_o,
  output logic [3:0]  dreq_wstrb_o,
  output logic [31:0] dreq_wdata_o,
  input  logic        dresp_valid_i,
  input  logic [31:0] dresp_rdata_i,
  input  logic        dresp_err_i,
  output logic [31:0] wb_value_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic        wb_we_o,
  output logic        lsu_trap_o,
  output logic [3:0]  lsu_trap_cause_o,
  output logic [31:0] lsu_trap_addr_o
);

  localparam logic [1:0] OpLoad  = 2'd1;
  localparam logic [1:0] OpStore = 2'd2;

  localparam logic [2:0] WidthB  = 3'd0;
  localparam logic [2:0] WidthH  = 3'd1;
  localparam logic [2:0] WidthW  = 3'd2;
  localparam logic [2:0] WidthBu = 3'd4;
  localparam logic [2:0] WidthHu = 3'd5;

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  width_q, width_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;

  logic        op_valid;
  logic        misaligned;
  logic        trap_misalign;
  logic        accept;
  logic        resp_fire;
  logic [31:0] addr_cap;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Decode of the op presented by execute.
  always_comb begin
    op_valid   = (lsu_op_typ_i == OpLoad) || (lsu_op_typ_i == OpStore);
    misaligned = 1'b0;
    addr_cap   = lsu_addr_i;
    case (lsu_width_i)
      WidthH, WidthHu: begin
        misaligned  = lsu_addr_i[0];
        addr_cap[0] = (TRAP_MISALIGN != 0) ? lsu_addr_i[0] : 1'b0;
      end
      WidthW: begin
        misaligned    = (lsu_addr_i[1:0] != 2'b00);
        addr_cap[1:0] = (TRAP_MISALIGN != 0) ? lsu_addr_i[1:0] : 2'b00;
      end
      default: ;
    endcase
    trap_misalign = (TRAP_MISALIGN != 0) && (state_q == StIdle) && op_valid && misaligned;
    accept        = (state_q == StIdle) && op_valid && !trap_misalign;
    resp_fire     = (state_q == StResp) && dresp_valid_i;
  end

  // Next state and capture.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    width_d    = width_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          is_store_d = (lsu_op_typ_i == OpStore);
          width_d    = lsu_width_i;
          addr_d     = addr_cap;
          wdata_d    = lsu_wdata_i;
          rd_d       = rd_addr_i;
          state_d    = StReq;
        end
      end
      // A response seen here is not ours yet; only RESP accepts one.
      StReq:  if (dreq_ready_i) state_d = StResp;
      StResp: if (dresp_valid_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      is_store_q <= 1'b0;
      width_q    <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rd_q       <= 5'd0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      width_q    <= width_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
    end
  end

  // Bus request comes purely from captured fields, so it is stable while in REQ.
  always_comb begin
    dreq_valid_o = (state_q == StReq);
    dreq_addr_o  = {addr_q[31:2], 2'b00};
    dreq_we_o    = is_store_q;
    case (width_q)
      WidthB: begin
        dreq_wstrb_o = 4'b0001 << addr_q[1:0];
        dreq_wdata_o = {4{wdata_q[7:0]}};
      end
      WidthH: begin
        dreq_wstrb_o = addr_q[1] ? 4'b1100 : 4'b0011;
        dreq_wdata_o = {2{wdata_q[15:0]}};
      end
      default: begin
        dreq_wstrb_o = 4'b1111;
        dreq_wdata_o = wdata_q;
      end
    endcase
  end

  // Load lane select and extension.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = dresp_rdata_i[7:0];
      2'd1:    ld_byte = dresp_rdata_i[15:8];
      2'd2:    ld_byte = dresp_rdata_i[23:16];
      default: ld_byte = dresp_rdata_i[31:24];
    endcase
    ld_half = addr_q[1] ? dresp_rdata_i[31:16] : dresp_rdata_i[15:0];
    case (width_q)
      WidthB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      WidthBu: ld_data = {24'd0, ld_byte};
      WidthH:  ld_data = {{16{ld_half[15]}}, ld_half};
      WidthHu: ld_data = {16'd0, ld_half};
      default: ld_data = dresp_rdata_i;
    endcase
  end

  // Back-pressure, write-back mux and traps.
  always_comb begin
    lsu_bp_o = accept || (state_q == StReq) || ((state_q == StResp) && !dresp_valid_i);

    wb_value_o   = ex_result_i;
    wb_rd_addr_o = ex_rd_addr_i;
    wb_we_o      = ex_we_rd_i && (ex_rd_addr_i != 5'd0);

    lsu_trap_o       = 1'b0;
    lsu_trap_cause_o = 4'd0;
    lsu_trap_addr_o  = 32'd0;

    if (trap_misalign) begin
      lsu_trap_o       = 1'b1;
      lsu_trap_cause_o = (lsu_op_typ_i == OpStore) ? 4'd6 : 4'd4;
      lsu_trap_addr_o  = lsu_addr_i;
    end

    if (resp_fire) begin
      if (dresp_err_i) begin
        lsu_trap_o       = 1'b1;
        lsu_trap_cause_o = is_store_q ? 4'd7 : 4'd5;
        lsu_trap_addr_o  = addr_q;
        wb_we_o          = 1'b0;
      end else if (!is_store_q) begin
        wb_value_o   = ld_data;
        wb_rd_addr_o = rd_q;
        wb_we_o      = (rd_q != 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem.sv
module tb_lsu_mem;

  localparam logic [1:0] OpNone  = 2'd0;
  localparam logic [1:0] OpLoad  = 2'd1;
  localparam logic [1:0] OpStore = 2'd2;

  logic        clk;
  logic        rst;
  logic [1:0]  lsu_op_typ;
  logic [2:0]  lsu_width;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [4:0]  rd_addr;
  logic [31:0] ex_result;
  logic [4:0]  ex_rd_addr;
  logic        ex_we_rd;
  logic        lsu_bp;
  logic        dreq_valid;
  logic        dreq_ready;
  logic [31:0] dreq_addr;
  logic        dreq_we;
  logic [3:0]  dreq_wstrb;
  logic [31:0] dreq_wdata;
  logic        dresp_valid;
  logic [31:0] dresp_rdata;
  logic        dresp_err;
  logic [31:0] wb_value;
  logic [4:0]  wb_rd_addr;
  logic        wb_we;
  logic        lsu_trap;
  logic [3:0]  lsu_trap_cause;
  logic [31:0] lsu_trap_addr;

  int errors = 0;
  int checks = 0;

  lsu_mem #(.TRAP_MISALIGN(1)) dut (
    .clk              (clk),
    .rst              (rst),
    .lsu_op_typ_i     (lsu_op_typ),
    .lsu_width_i      (lsu_width),
    .lsu_addr_i       (lsu_addr),
    .lsu_wdata_i      (lsu_wdata),
    .rd_addr_i        (rd_addr),
    .ex_result_i      (ex_result),
    .ex_rd_addr_i     (ex_rd_addr),
    .ex_we_rd_i       (ex_we_rd),
    .lsu_bp_o         (lsu_bp),
    .dreq_valid_o     (dreq_valid),
    .dreq_ready_i     (dreq_ready),
    .dreq_addr_o      (dreq_addr),
    .dreq_we_o        (dreq_we),
    .dreq_wstrb_o     (dreq_wstrb),
    .dreq_wdata_o     (dreq_wdata),
    .dresp_valid_i    (dresp_valid),
    .dresp_rdata_i    (dresp_rdata),
    .dresp_err_i      (dresp_err),
    .wb_value_o       (wb_value),
    .wb_rd_addr_o     (wb_rd_addr),
    .wb_we_o          (wb_we),
    .lsu_trap_o       (lsu_trap),
    .lsu_trap_cause_o (lsu_trap_cause),
    .lsu_trap_addr_o  (lsu_trap_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change right after the falling edge; outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic quiet();
    lsu_op_typ  = OpNone;
    lsu_width   = 3'd0;
    lsu_addr    = 32'd0;
    lsu_wdata   = 32'd0;
    rd_addr     = 5'd0;
    ex_result   = 32'd0;
    ex_rd_addr  = 5'd0;
    ex_we_rd    = 1'b0;
    dreq_ready  = 1'b0;
    dresp_valid = 1'b0;
    dresp_rdata = 32'd0;
    dresp_err   = 1'b0;
  endtask

  task automatic present(input logic [1:0] op, input logic [2:0] w, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd);
    lsu_op_typ = op;
    lsu_width  = w;
    lsu_addr   = a;
    lsu_wdata  = d;
    rd_addr    = rd;
  endtask

  task automatic test_reset();
    quiet();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
    checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL reset_dreq_valid got %b exp 0", dreq_valid); end
    checks++; if (lsu_bp !== 1'b0) begin errors++; $display("FAIL reset_bp got %b exp 0", lsu_bp); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_wb_we got %b exp 0", wb_we); end
    checks++; if (lsu_trap !== 1'b0) begin errors++; $display("FAIL reset_trap got %b exp 0", lsu_trap); end
  endtask

  task automatic test_passthrough();
    next_cycle();
    ex_result = 32'h11223344; ex_rd_addr = 5'd7; ex_we_rd = 1'b1;
    #1;
    checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL pass_we got %b exp 1", wb_we); end
    checks++; if (wb_rd_addr !== 5'd7) begin errors++; $display("FAIL pass_rd got %0d exp 7", wb_rd_addr); end
    checks++; if (wb_value !== 32'h11223344) begin errors++; $display("FAIL pass_value got %h exp 11223344", wb_value); end
    next_cycle();
    ex_rd_addr = 5'd0;
    #1;
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL pass_x0_we got %b exp 0", wb_we); end
    quiet();
  endtask

  task automatic test_load_word();
    next_cycle();
    present(OpLoad, 3'd2, 32'h100, 32'd0, 5'd5);
    #1;
    checks++; if (lsu_bp !== 1'b1) begin errors++; $display("FAIL lw_c0_bp got %b exp 1", lsu_bp); end
    checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL lw_c0_valid got %b exp 0", dreq_valid); end
    next_cycle();
    dreq_ready = 1'b1;
    #1;
    checks++; if (lsu_bp !== 1'b1) begin errors++; $display("FAIL lw_c1_bp got %b exp 1", lsu_bp); end
    checks++; if (dreq_valid !== 1'b1) begin errors++; $display("FAIL lw_c1_valid got %b exp 1", dreq_valid); end
    checks++; if (dreq_addr !== 32'h100) begin errors++; $display("FAIL lw_c1_addr got %h exp 00000100", dreq_addr); end
    checks++; if (dreq_we !== 1'b0) begin errors++; $display("FAIL lw_c1_we got %b exp 0", dreq_we); end
    next_cycle();
    dreq_ready = 1'b0; dresp_valid = 1'b1; dresp_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (lsu_bp !== 1'b0) begin errors++; $display("FAIL lw_c2_bp got %b exp 0", lsu_bp); end
    checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL lw_c2_wb_we got %b exp 1", wb_we); end
    checks++; if (wb_rd_addr !== 5'd5) begin errors++; $display("FAIL lw_c2_rd got %0d exp 5", wb_rd_addr); end
    checks++; if (wb_value !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_c2_value got %h exp deadbeef", wb_value); end
    next_cycle();
    quiet();
    #1;
    checks++; if (lsu_bp !== 1'b0) begin errors++; $display("FAIL lw_c3_bp got %b exp 0", lsu_bp); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL lw_c3_wb_we got %b exp 0", wb_we); end
  endtask

  task automatic test_load_extract();
    logic [2:0]  w_v [5] = '{3'd0, 3'd4, 3'd5, 3'd1, 3'd0};
    logic [31:0] a_v [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101};
    logic [31:0] r_v [5] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'hBEEF1234, 32'hBEEF1234, 32'h12347F56};
    logic [31:0] e_v [5] = '{32'hFFFFFF80, 32'h00000080, 32'h0000BEEF, 32'hFFFFBEEF, 32'h0000007F};
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      present(OpLoad, w_v[i], a_v[i], 32'd0, 5'd9);
      next_cycle();
      dreq_ready = 1'b1;
      next_cycle();
      dreq_ready = 1'b0; dresp_valid = 1'b1; dresp_rdata = r_v[i];
      #1;
      checks++; if (wb_value !== e_v[i]) begin errors++; $display("FAIL ld_extract[%0d] value got %h exp %h", i, wb_value, e_v[i]); end
      checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL ld_extract[%0d] we got %b exp 1", i, wb_we); end
      next_cycle();
      quiet();
    end
  endtask

  task automatic test_store_lanes();
    logic [2:0]  w_v [3] = '{3'd0, 3'd1, 3'd2};
    logic [31:0] a_v [3] = '{32'h201, 32'h202, 32'h204};
    logic [31:0] ea_v [3] = '{32'h200, 32'h200, 32'h204};
    logic [3:0]  es_v [3] = '{4'b0010, 4'b1100, 4'b1111};
    logic [31:0] ed_v [3] = '{32'h78787878, 32'h56785678, 32'h12345678};
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      present(OpStore, w_v[i], a_v[i], 32'h12345678, 5'd0);
      next_cycle();
      dreq_ready = 1'b1;
      #1;
      checks++; if (dreq_we !== 1'b1) begin errors++; $display("FAIL st[%0d] we got %b exp 1", i, dreq_we); end
      checks++; if (dreq_addr !== ea_v[i]) begin errors++; $display("FAIL st[%0d] addr got %h exp %h", i, dreq_addr, ea_v[i]); end
      checks++; if (dreq_wstrb !== es_v[i]) begin errors++; $display("FAIL st[%0d] wstrb got %b exp %b", i, dreq_wstrb, es_v[i]); end
      checks++; if (dreq_wdata !== ed_v[i]) begin errors++; $display("FAIL st[%0d] wdata got %h exp %h", i, dreq_wdata, ed_v[i]); end
      next_cycle();
      dreq_ready = 1'b0; dresp_valid = 1'b1;
      #1;
      checks++; if (lsu_bp !== 1'b0) begin errors++; $display("FAIL st[%0d] resp_bp got %b exp 0", i, lsu_bp); end
      checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL st[%0d] resp_wb_we got %b exp 0", i, wb_we); end
      checks++; if (lsu_trap !== 1'b0) begin errors++; $display("FAIL st[%0d] resp_trap got %b exp 0", i, lsu_trap); end
      next_cycle();
      quiet();
    end
  endtask

  task automatic test_store_wait_err();
    next_cycle();
    present(OpStore, 3'd2, 32'h300, 32'hCAFEF00D, 5'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #1;
      checks++;
      if (dreq_valid !== 1'b1 || dreq_addr !== 32'h300 || dreq_wstrb !== 4'hF ||
          dreq_wdata !== 32'hCAFEF00D || lsu_bp !== 1'b1) begin
        errors++;
        $display("FAIL sw_wait[%0d] got v=%b a=%h s=%b d=%h bp=%b exp v=1 a=00000300 s=1111 d=cafef00d bp=1",
                 i, dreq_valid, dreq_addr, dreq_wstrb, dreq_wdata, lsu_bp);
      end
    end
    next_cycle();
    dreq_ready = 1'b1;
    next_cycle();
    dreq_ready = 1'b0;
    #1;
    checks++; if (lsu_bp !== 1'b1) begin errors++; $display("FAIL sw_resp_wait_bp got %b exp 1", lsu_bp); end
    checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL sw_resp_wait_valid got %b exp 0", dreq_valid); end
    next_cycle();
    dresp_valid = 1'b1; dresp_err = 1'b1;
    #1;
    checks++; if (lsu_trap !== 1'b1) begin errors++; $display("FAIL sw_err_trap got %b exp 1", lsu_trap); end
    checks++; if (lsu_trap_cause !== 4'd7) begin errors++; $display("FAIL sw_err_cause got %0d exp 7", lsu_trap_cause); end
    checks++; if (lsu_trap_addr !== 32'h300) begin errors++; $display("FAIL sw_err_addr got %h exp 00000300", lsu_trap_addr); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL sw_err_wb_we got %b exp 0", wb_we); end
    checks++; if (lsu_bp !== 1'b0) begin errors++; $display("FAIL sw_err_bp got %b exp 0", lsu_bp); end
    next_cycle();
    quiet();
    #1;
    checks++; if (lsu_trap !== 1'b0) begin errors++; $display("FAIL sw_err_trap_drop got %b exp 0", lsu_trap); end
  endtask

  task automatic test_misaligned();
    next_cycle();
    present(OpLoad, 3'd2, 32'h102, 32'd0, 5'd5);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL mis_lw[%0d] valid got %b exp 0", i, dreq_valid); end
      checks++; if (lsu_trap !== 1'b1) begin errors++; $display("FAIL mis_lw[%0d] trap got %b exp 1", i, lsu_trap); end
      checks++; if (lsu_trap_cause !== 4'd4) begin errors++; $display("FAIL mis_lw[%0d] cause got %0d exp 4", i, lsu_trap_cause); end
      checks++; if (lsu_trap_addr !== 32'h102) begin errors++; $display("FAIL mis_lw[%0d] addr got %h exp 00000102", i, lsu_trap_addr); end
      checks++; if (lsu_bp !== 1'b0) begin errors++; $display("FAIL mis_lw[%0d] bp got %b exp 0", i, lsu_bp); end
      next_cycle();
    end
    present(OpStore, 3'd1, 32'h201, 32'h0, 5'd0);
    #1;
    checks++; if (lsu_trap_cause !== 4'd6) begin errors++; $display("FAIL mis_sh cause got %0d exp 6", lsu_trap_cause); end
    checks++; if (lsu_trap_addr !== 32'h201) begin errors++; $display("FAIL mis_sh addr got %h exp 00000201", lsu_trap_addr); end
    next_cycle();
    quiet();
    #1;
    checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL mis_after valid got %b exp 0", dreq_valid); end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    present(OpLoad, 3'd2, 32'h400, 32'd0, 5'd3);
    next_cycle();
    // Stray response together with the handshake must be ignored.
    dreq_ready = 1'b1; dresp_valid = 1'b1; dresp_rdata = 32'h0BAD0BAD;
    #1;
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL b2b_stray_we got %b exp 0", wb_we); end
    next_cycle();
    dreq_ready = 1'b0; dresp_valid = 1'b0;
    #1;
    checks++; if (lsu_bp !== 1'b1) begin errors++; $display("FAIL b2b_wait_bp got %b exp 1", lsu_bp); end
    next_cycle();
    dresp_valid = 1'b1; dresp_rdata = 32'hA5A5A5A5;
    #1;
    checks++; if (wb_value !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_first value got %h exp a5a5a5a5", wb_value); end
    checks++; if (wb_rd_addr !== 5'd3) begin errors++; $display("FAIL b2b_first rd got %0d exp 3", wb_rd_addr); end
    next_cycle();
    dresp_valid = 1'b0;
    present(OpLoad, 3'd5, 32'h402, 32'd0, 5'd4);
    #1;
    checks++; if (lsu_bp !== 1'b1) begin errors++; $display("FAIL b2b_second_capture bp got %b exp 1", lsu_bp); end
    checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL b2b_second_capture valid got %b exp 0", dreq_valid); end
    next_cycle();
    dreq_ready = 1'b1;
    #1;
    checks++; if (dreq_addr !== 32'h400) begin errors++; $display("FAIL b2b_second addr got %h exp 00000400", dreq_addr); end
    next_cycle();
    dreq_ready = 1'b0; dresp_valid = 1'b1; dresp_rdata = 32'h7FFF0000;
    #1;
    checks++; if (wb_value !== 32'h00007FFF) begin errors++; $display("FAIL b2b_second value got %h exp 00007fff", wb_value); end
    checks++; if (wb_rd_addr !== 5'd4) begin errors++; $display("FAIL b2b_second rd got %0d exp 4", wb_rd_addr); end
    next_cycle();
    quiet();
  endtask

  task automatic test_reset_mid();
    next_cycle();
    present(OpLoad, 3'd2, 32'h500, 32'd0, 5'd6);
    next_cycle();
    dreq_ready = 1'b1;
    next_cycle();
    quiet();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    dresp_valid = 1'b1; dresp_rdata = 32'h55555555;
    #1;
    checks++; if (lsu_bp !== 1'b0) begin errors++; $display("FAIL rstmid_bp got %b exp 0", lsu_bp); end
    checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", dreq_valid); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL rstmid_wb_we got %b exp 0", wb_we); end
    checks++; if (lsu_trap !== 1'b0) begin errors++; $display("FAIL rstmid_trap got %b exp 0", lsu_trap); end
    next_cycle();
    quiet();
  endtask

  task automatic test_load_x0();
    next_cycle();
    present(OpLoad, 3'd2, 32'h104, 32'd0, 5'd0);
    next_cycle();
    dreq_ready = 1'b1;
    #1;
    checks++; if (dreq_valid !== 1'b1) begin errors++; $display("FAIL x0_valid got %b exp 1", dreq_valid); end
    next_cycle();
    dreq_ready = 1'b0; dresp_valid = 1'b1; dresp_rdata = 32'h12345678;
    #1;
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL x0_wb_we got %b exp 0", wb_we); end
    checks++; if (lsu_bp !== 1'b0) begin errors++; $display("FAIL x0_bp got %b exp 0", lsu_bp); end
    next_cycle();
    quiet();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_word();
    test_load_extract();
    test_store_lanes();
    test_store_wait_err();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    test_load_x0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem.md
# lsu_mem

Memory/write-back stage directly downstream of the execute stage. Consumes the execute stage's load/store descriptor and its registered ALU result, issues one data-bus transaction per load/store, back-pressures execute until the transaction completes, aligns and extends load data, and drives the single register-file write-back port. That write-back value is also the forwarding value returned to execute.

## Interface
Parameters:
- TRAP_MISALIGN, default 1 — 1: misaligned half/word accesses raise a trap and never reach the bus; 0: the low address bits are ignored and the access is word/half-aligned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- lsu_i  in  s_lsu_op_t  op_typ (NO_LSU / LSU_LOAD / LSU_STORE), width (f3: 0 B, 1 H, 2 W, 4 BU, 5 HU), addr[31:0], wdata[31:0].
- rd_addr_i  in  5  destination register of the instruction currently in execute.
- ex_mem_wb_i  in  s_ex_mem_wb_t  registered execute result: result[31:0], rd_addr, we_rd.
- lsu_bp_o  out  1  back-pressure to execute.
- dreq_valid_o  out  1  bus request valid.
- dreq_ready_i  in  1  bus request accepted.
- dreq_addr_o  out  32  word address; bits [1:0] are forced to 0.
- dreq_we_o  out  1  1 = store.
- dreq_wstrb_o  out  4  byte strobes.
- dreq_wdata_o  out  32  lane-replicated store data.
- dresp_valid_i  in  1  response valid; a single-cycle pulse.
- dresp_rdata_i  in  32  load data word.
- dresp_err_i  in  1  bus error, qualified by dresp_valid_i.
- wb_value_o  out  32  register-file write data; also the forwarding value.
- wb_rd_addr_o  out  5  register-file write address.
- wb_we_o  out  1  register-file write enable.
- lsu_trap_o  out  1  trap request.
- lsu_trap_cause_o  out  4  4 load-misaligned, 5 load-fault, 6 store-misaligned, 7 store-fault.
- lsu_trap_addr_o  out  32  faulting byte address.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - lsu_i.op_typ != NO_LSU and aligned: capture op, width, addr, wdata and rd_addr_i; go to REQ.
  - Misaligned and TRAP_MISALIGN=1: assert lsu_trap_o combinationally for every cycle the op is presented; no bus request; stay in IDLE.
- REQ:
  - dreq_valid_o=1; addr, we, wstrb and wdata stay stable until dreq_ready_i.
  - On the handshake, go to RESP.
- RESP:
  - On dresp_valid_i, go to IDLE.
  - Load without error: wb_we_o=1, wb_rd_addr_o=captured rd, wb_value_o=extracted data, all in that same cycle. If the captured rd is 0, wb_we_o=0.
  - dresp_err_i=1: 1-cycle lsu_trap_o, cause 5 (load) or 7 (store), lsu_trap_addr_o=captured addr, no write-back.
  - Stores complete on the response; they never write back.
- lsu_bp_o = (IDLE and valid aligned op) or REQ or (RESP and not dresp_valid_i).
  - It drops in the response cycle, so execute advances exactly once.
  - Because it drops in the response cycle, the same op is not re-captured.
- Store lanes:
  - B: wstrb = 1<<addr[1:0], wdata = {4{byte}}.
  - H: wstrb = 0011 or 1100 (addr[1]), wdata = {2{half}}.
  - W: wstrb = 1111.
- Load extract:
  - Select the byte lane by addr[1:0], the half lane by addr[1].
  - Sign-extend for B/H, zero-extend for BU/HU.
- Write-back mux: the load response takes priority. Otherwise wb_* = ex_mem_wb_i, with wb_we_o forced to 0 when rd_addr==0.
  - During a stall, execute holds ex_mem_wb_i, so the repeated write of the same value is intentional and idempotent.
- Reset values:
  - State IDLE; captured fields 0.
  - All outputs 0: dreq_valid_o, lsu_bp_o, wb_we_o, lsu_trap_o.
- Reset mid-transaction: return to IDLE and drop dreq_valid_o; a stale dresp_valid_i arriving in IDLE is ignored.

## Timing
- Minimum load latency, zero-wait bus: cycle 0 IDLE capture (bp=1); cycle 1 REQ handshake (bp=1); cycle 2 RESP with response: write-back and bp=0.
- Total: 3 cycles, with execute stalled for 2.
- Each dreq_ready_i wait cycle and each response wait cycle adds one cycle.
- Trap outputs and write-back are combinational in the cycle of the triggering event; there are no registered extra cycles.
- Simultaneous dreq_ready_i and dresp_valid_i in REQ: the response is ignored; responses are accepted only in RESP.

## Test plan
- LW at 0x100, rd=x5, bus returns 0xDEADBEEF with 0 waits → bp high for 2 cycles; wb_we=1, rd=5, value 0xDEADBEEF in cycle 2.
- LB at 0x103 with rdata 0x80FFFFFF → wb_value 0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 with rdata 0xBEEF1234 → 0x0000BEEF.
- SB at 0x201, data 0x12345678 → dreq_addr 0x200, wstrb 0010, wdata 0x78787878. SH at 0x202 → wstrb 1100, wdata 0x56785678.
- LW at 0x102 with TRAP_MISALIGN=1 → no dreq_valid, trap=1, cause 4, trap_addr 0x102, bp=0.
- SW with dreq_ready low for 3 cycles, then a response with err=1 → request fields stable throughout; trap cause 7, no write-back.
- rst asserted while in RESP, then dresp_valid arrives a cycle later → IDLE, all outputs 0, response ignored. Also: a load to x0 → wb_we stays 0.
